// File: rtl/dram_cache_pkg.sv
// Shared types and constants for the DRAM-side tag/data responder.
package dram_cache_pkg;

  localparam int unsigned TAG_W  = 56;
  localparam int unsigned DATA_W = 72;

  // Reserved tag that is never filled, so the comparator always sees a miss.
  localparam logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}};

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/dram_tag_responder_if.sv
// AR request, R response and fill signals of the tag/data responder.
interface dram_tag_responder_if import dram_cache_pkg::*; #(
  parameter int unsigned IDX_W = 4
);

  logic              arvalid_i;
  logic              arready_o;
  logic [IDX_W-1:0]  arindex_i;
  logic [DATA_W-1:0] rdata_o;
  logic [TAG_W-1:0]  rtag_o;
  logic              rvalid_o;
  logic              rready_i;
  logic              fill_valid_i;
  logic [IDX_W-1:0]  fill_index_i;
  logic [TAG_W-1:0]  fill_tag_i;
  logic [DATA_W-1:0] fill_data_i;

  // Responder side.
  modport slave (
    input  arvalid_i, arindex_i, rready_i, fill_valid_i, fill_index_i, fill_tag_i, fill_data_i,
    output arready_o, rdata_o, rtag_o, rvalid_o
  );

  // Requester / consumer side.
  modport master (
    output arvalid_i, arindex_i, rready_i, fill_valid_i, fill_index_i, fill_tag_i, fill_data_i,
    input  arready_o, rdata_o, rtag_o, rvalid_o
  );

endinterface

// File: rtl/resp_fifo.sv
// Synchronous FIFO of resp_t entries; full/empty derived from the occupancy count.
module resp_fifo import dram_cache_pkg::*; #(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  resp_t                    data_i,
  input  logic                     pop_i,
  output resp_t                    head_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  resp_t             mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (do_pop) rptr_d = rptr_q + 1'b1;
    if (push_i && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; only occupied slots are ever observed.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/dram_tag_responder.sv
// Direct-mapped tag/data array with fixed-latency read pipeline, response FIFO and credit counter.
module dram_tag_responder import dram_cache_pkg::*; #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned RESP_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  dram_tag_responder_if.slave  bus
);

  localparam int unsigned NumLines = 2 ** IDX_W;
  localparam int unsigned CntW     = $clog2(RESP_DEPTH) + 1;
  localparam logic [CntW-1:0] MaxOut = CntW'(RESP_DEPTH);

  logic [NumLines-1:0] line_vld_q;
  logic [TAG_W-1:0]    tag_q  [NumLines];
  logic [DATA_W-1:0]   data_q [NumLines];

  logic [READ_LAT-1:0] pipe_vld_q;
  resp_t               pipe_q [READ_LAT];

  logic [CntW-1:0]     outstanding_q, outstanding_d;
  logic                ar_acc, r_pop;
  resp_t               lookup;
  resp_t               fifo_head;
  logic                fifo_empty;
  logic [CntW-1:0]     fifo_count;

  assign bus.arready_o = (outstanding_q < MaxOut);
  assign ar_acc        = bus.arvalid_i && bus.arready_o;
  assign r_pop         = bus.rvalid_o && bus.rready_i;

  // Combinational lookup sees the array before this edge's fill (read-before-write).
  always_comb begin
    lookup.tag  = INVALID_TAG;
    lookup.data = '0;
    if (line_vld_q[bus.arindex_i]) begin
      lookup.tag  = tag_q[bus.arindex_i];
      lookup.data = data_q[bus.arindex_i];
    end
  end

  // Line valid bits; reset invalidates every line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_vld_q <= '0;
    end else if (bus.fill_valid_i) begin
      line_vld_q[bus.fill_index_i] <= 1'b1;
    end
  end

  // Tag and data contents; unreset since the valid bit guards them.
  always_ff @(posedge clk) begin
    if (bus.fill_valid_i) begin
      tag_q[bus.fill_index_i]  <= bus.fill_tag_i;
      data_q[bus.fill_index_i] <= bus.fill_data_i;
    end
  end

  // Fixed-latency response pipeline; never stalls because credits bound the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= ar_acc;
      pipe_q[0]     <= lookup;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_q[i]     <= pipe_q[i-1];
      end
    end
  end

  // Credit counter next-state: +1 per accept, -1 per pop.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({ar_acc, r_pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Credit counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outstanding_q <= '0;
    else        outstanding_q <= outstanding_d;
  end

  resp_fifo #(
    .Depth (RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (pipe_vld_q[READ_LAT-1]),
    .data_i  (pipe_q[READ_LAT-1]),
    .pop_i   (r_pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Outputs read zero while empty so reset values appear asynchronously.
  assign bus.rvalid_o = !fifo_empty;
  assign bus.rtag_o   = fifo_empty ? '0 : fifo_head.tag;
  assign bus.rdata_o  = fifo_empty ? '0 : fifo_head.data;

  // The credit scheme must keep the pipeline from pushing into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    pipe_vld_q[READ_LAT-1] |-> (fifo_count < MaxOut || r_pop));

endmodule

// File: tb/tb_dram_tag_responder.sv
// Directed bench for dram_tag_responder with hand-computed expectations.
module tb_dram_tag_responder;
  import dram_cache_pkg::*;

  localparam int unsigned IDX_W = 4;
  localparam logic [TAG_W-1:0] InvTag = {TAG_W{1'b1}};

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  dram_tag_responder_if #(.IDX_W(IDX_W)) bus ();

  dram_tag_responder #(
    .IDX_W      (IDX_W),
    .READ_LAT   (2),
    .RESP_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int idx, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    bus.fill_valid_i = 1'b1;
    bus.fill_index_i = IDX_W'(idx);
    bus.fill_tag_i   = tag;
    bus.fill_data_i  = data;
    tick();
    bus.fill_valid_i = 1'b0;
  endtask

  initial begin
    logic [TAG_W-1:0]  got_tag [$];
    logic [DATA_W-1:0] got_data [$];
    int acc, first_hi, last_hi, n_hi, n_lo;
    logic accept, pop;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.arvalid_i    = 1'b0;
    bus.arindex_i    = '0;
    bus.rready_i     = 1'b0;
    bus.fill_valid_i = 1'b0;
    bus.fill_index_i = '0;
    bus.fill_tag_i   = '0;
    bus.fill_data_i  = '0;

    // Reset defaults
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_arready", 128'(bus.arready_o), 128'd1);
    check_eq("rst_rvalid",  128'(bus.rvalid_o),  128'd0);
    check_eq("rst_rtag",    128'(bus.rtag_o),    128'd0);
    check_eq("rst_rdata",   128'(bus.rdata_o),   128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Unfilled line reads as invalid after READ_LAT
    bus.arvalid_i = 1'b1;
    bus.arindex_i = 4'd3;
    tick();
    bus.arvalid_i = 1'b0;
    tick();
    check_eq("t1_lat_early", 128'(bus.rvalid_o), 128'd0);
    tick();
    check_eq("t1_rvalid", 128'(bus.rvalid_o), 128'd1);
    check_eq("t1_rtag",   128'(bus.rtag_o),   128'(InvTag));
    check_eq("t1_rdata",  128'(bus.rdata_o),  128'd0);
    bus.rready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0;
    check_eq("t1_popped", 128'(bus.rvalid_o), 128'd0);

    // Fill then read
    fill(5, 56'd10, 72'd100);
    bus.arvalid_i = 1'b1;
    bus.arindex_i = 4'd5;
    bus.rready_i  = 1'b1;
    tick();
    bus.arvalid_i = 1'b0;
    tick();
    check_eq("t2_lat_early", 128'(bus.rvalid_o), 128'd0);
    tick();
    check_eq("t2_rvalid", 128'(bus.rvalid_o), 128'd1);
    check_eq("t2_rtag",   128'(bus.rtag_o),   128'd10);
    check_eq("t2_rdata",  128'(bus.rdata_o),  128'd100);
    tick();
    check_eq("t2_popped", 128'(bus.rvalid_o), 128'd0);

    // Same-edge fill and read: first read misses, second hits
    bus.fill_valid_i = 1'b1;
    bus.fill_index_i = 4'd7;
    bus.fill_tag_i   = 56'd20;
    bus.fill_data_i  = 72'd200;
    bus.arvalid_i    = 1'b1;
    bus.arindex_i    = 4'd7;
    tick();
    bus.fill_valid_i = 1'b0;
    tick();
    bus.arvalid_i = 1'b0;
    tick();
    check_eq("t3_same_edge_tag", 128'(bus.rtag_o), 128'(InvTag));
    check_eq("t3_same_edge_data", 128'(bus.rdata_o), 128'd0);
    tick();
    check_eq("t3_later_tag",  128'(bus.rtag_o),  128'd20);
    check_eq("t3_later_data", 128'(bus.rdata_o), 128'd200);
    tick();
    check_eq("t3_drained", 128'(bus.rvalid_o), 128'd0);
    bus.rready_i = 1'b0;

    // Back-pressure: credits limit outstanding to 4, order preserved on release
    for (int i = 0; i < 6; i++) fill(i, 56'(i), 72'(i + 'h1000));
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 8) bus.rready_i = 1'b1;
      bus.arvalid_i = (acc < 6);
      bus.arindex_i = IDX_W'(acc);
      if (c == 4) check_eq("t4_hold_tag_early", 128'(bus.rtag_o), 128'd0);
      if (c == 7) begin
        check_eq("t4_accepts", 128'(acc), 128'd4);
        check_eq("t4_arready_low", 128'(bus.arready_o), 128'd0);
        check_eq("t4_hold_tag", 128'(bus.rtag_o), 128'd0);
        check_eq("t4_hold_data", 128'(bus.rdata_o), 128'h1000);
      end
      accept = bus.arvalid_i && bus.arready_o;
      pop    = bus.rvalid_o && bus.rready_i;
      if (pop) begin
        got_tag.push_back(bus.rtag_o);
        got_data.push_back(bus.rdata_o);
      end
      tick();
      if (accept) acc++;
    end
    bus.arvalid_i = 1'b0;
    check_eq("t4_resp_count", 128'(got_tag.size()), 128'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_tag.size()) begin
        check_eq("t4_order_tag",  128'(got_tag[i]),  128'(i));
        check_eq("t4_order_data", 128'(got_data[i]), 128'(i + 'h1000));
      end
    end

    // Streaming: 16 back-to-back requests with rready held high
    bus.rready_i = 1'b1;
    first_hi = -1;
    last_hi  = -1;
    n_hi     = 0;
    n_lo     = 0;
    for (int c = 0; c < 24; c++) begin
      bus.arvalid_i = (c < 16);
      bus.arindex_i = IDX_W'(c);
      if (bus.rvalid_o) begin
        n_hi++;
        if (first_hi < 0) first_hi = c;
        last_hi = c;
      end
      if (c < 16 && !bus.arready_o) n_lo++;
      tick();
    end
    bus.arvalid_i = 1'b0;
    check_eq("t5_rvalid_cycles", 128'(n_hi), 128'd16);
    check_eq("t5_first_resp",    128'(first_hi), 128'd3);
    check_eq("t5_no_gaps",       128'(last_hi - first_hi), 128'd15);
    check_eq("t5_arready_low",   128'(n_lo), 128'd0);

    // Reset mid-stream with three responses buffered
    bus.rready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.arvalid_i = 1'b1;
      bus.arindex_i = IDX_W'(i);
      tick();
    end
    bus.arvalid_i = 1'b0;
    repeat (3) tick();
    check_eq("t6_buffered", 128'(bus.rvalid_o), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_rvalid", 128'(bus.rvalid_o), 128'd0);
    check_eq("t6_async_rtag",   128'(bus.rtag_o),   128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("t6_arready", 128'(bus.arready_o), 128'd1);
    check_eq("t6_rvalid",  128'(bus.rvalid_o),  128'd0);
    bus.arvalid_i = 1'b1;
    bus.arindex_i = 4'd0;
    tick();
    bus.arvalid_i = 1'b0;
    repeat (2) tick();
    check_eq("t6_inv_rvalid", 128'(bus.rvalid_o), 128'd1);
    check_eq("t6_inv_tag",    128'(bus.rtag_o),   128'(InvTag));
    check_eq("t6_inv_data",   128'(bus.rdata_o),  128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
